// File: rtl/vga_cfg_pkg.sv
// Shared VGA timing constants for the 1024x768@60 (65 MHz) display path.
package vga_cfg_pkg;

  // Counter width wide enough for the larger of the horizontal and vertical totals.
  localparam int CNT_W = 11;

  // Horizontal timing in pixel clocks. Sync end is exclusive.
  localparam int H_ACTIVE_TIME = 1024;
  localparam int H_SYNC_START  = 1048;
  localparam int H_SYNC_END    = 1184;
  localparam int H_TOTAL_TIME  = 1344;

  // Vertical timing in lines. Sync end is exclusive.
  localparam int V_ACTIVE_TIME = 768;
  localparam int V_SYNC_START  = 771;
  localparam int V_SYNC_END    = 777;
  localparam int V_TOTAL_TIME  = 806;

endpackage

// File: rtl/vga_frame_ctrl_pkg.sv
// Types for the frame controller's update-window arbiter.
package vga_frame_ctrl_pkg;

  // IDLE: waiting for a request inside the window.
  // GRANTED: game logic owns the shared state.
  // USED: this frame's grant has been spent; wait for the next frame start.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANTED = 2'd1,
    USED    = 2'd2
  } upd_state_t;

endpackage

// File: rtl/vga_timing_gen.sv
// Pixel/line counters with sync, blanking and frame-start strobe.
// Every output is registered from the next-count value, so all of them line up
// with hcount/vcount in the same cycle. The next-line values are also exported
// so a consumer can react in the same cycle the registered outputs change.
module vga_timing_gen
  import vga_cfg_pkg::*;
#(
  parameter int H_TOTAL      = H_TOTAL_TIME,
  parameter int H_ACTIVE     = H_ACTIVE_TIME,
  parameter int H_SYNC_BEGIN = H_SYNC_START,
  parameter int H_SYNC_STOP  = H_SYNC_END,
  parameter int V_TOTAL      = V_TOTAL_TIME,
  parameter int V_ACTIVE     = V_ACTIVE_TIME,
  parameter int V_SYNC_BEGIN = V_SYNC_START,
  parameter int V_SYNC_STOP  = V_SYNC_END
) (
  input  logic             clk,
  input  logic             rst,
  output logic [CNT_W-1:0] hcount,
  output logic [CNT_W-1:0] vcount,
  output logic             hsync,
  output logic             vsync,
  output logic             hblnk,
  output logic             vblnk,
  output logic             frame_start,
  output logic [CNT_W-1:0] vcount_nxt,
  output logic             vblnk_nxt
);

  localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT   = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT   = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG  = CNT_W'(H_SYNC_BEGIN);
  localparam logic [CNT_W-1:0] HS_STOP = CNT_W'(H_SYNC_STOP);
  localparam logic [CNT_W-1:0] VS_BEG  = CNT_W'(V_SYNC_BEGIN);
  localparam logic [CNT_W-1:0] VS_STOP = CNT_W'(V_SYNC_STOP);

  logic [CNT_W-1:0] hcount_reg, hcount_next;
  logic [CNT_W-1:0] vcount_reg, vcount_next;
  logic             hsync_reg, vsync_reg, hblnk_reg, vblnk_reg, frame_start_reg;

  // Next counter values: horizontal always advances, vertical only on a line wrap.
  always_comb begin
    hcount_next = hcount_reg + 1'b1;
    vcount_next = vcount_reg;
    if (hcount_reg == H_LAST) begin
      hcount_next = '0;
      if (vcount_reg == V_LAST) begin
        vcount_next = '0;
      end else begin
        vcount_next = vcount_reg + 1'b1;
      end
    end
  end

  // Register counters and all derived outputs from the next-count values.
  always_ff @(posedge clk) begin
    if (rst) begin
      hcount_reg      <= '0;
      vcount_reg      <= '0;
      hsync_reg       <= 1'b0;
      vsync_reg       <= 1'b0;
      hblnk_reg       <= 1'b0;
      vblnk_reg       <= 1'b0;
      frame_start_reg <= 1'b0;
    end else begin
      hcount_reg      <= hcount_next;
      vcount_reg      <= vcount_next;
      hblnk_reg       <= (hcount_next >= H_ACT);
      hsync_reg       <= (hcount_next >= HS_BEG) && (hcount_next < HS_STOP);
      vblnk_reg       <= (vcount_next >= V_ACT);
      vsync_reg       <= (vcount_next >= VS_BEG) && (vcount_next < VS_STOP);
      frame_start_reg <= (hcount_next == '0) && (vcount_next == '0);
    end
  end

  assign hcount      = hcount_reg;
  assign vcount      = vcount_reg;
  assign hsync       = hsync_reg;
  assign vsync       = vsync_reg;
  assign hblnk       = hblnk_reg;
  assign vblnk       = vblnk_reg;
  assign frame_start = frame_start_reg;
  assign vcount_nxt  = vcount_next;
  assign vblnk_nxt   = (vcount_next >= V_ACT);

endmodule

// File: rtl/vga_frame_ctrl.sv
// VGA frame controller: display timing plus a one-grant-per-frame arbiter that
// hands display-shared state to game logic only inside vertical blanking.
// Grant starts from the window as currently shown; revocation looks at the
// next line so the grant is already low in the first cycle outside the window.
module vga_frame_ctrl
  import vga_cfg_pkg::*;
  import vga_frame_ctrl_pkg::*;
#(
  parameter int GUARD_LINES  = 1,
  parameter int H_TOTAL      = H_TOTAL_TIME,
  parameter int H_ACTIVE     = H_ACTIVE_TIME,
  parameter int H_SYNC_BEGIN = H_SYNC_START,
  parameter int H_SYNC_STOP  = H_SYNC_END,
  parameter int V_TOTAL      = V_TOTAL_TIME,
  parameter int V_ACTIVE     = V_ACTIVE_TIME,
  parameter int V_SYNC_BEGIN = V_SYNC_START,
  parameter int V_SYNC_STOP  = V_SYNC_END
) (
  input  logic             clk,
  input  logic             rst,
  output logic [CNT_W-1:0] hcount,
  output logic [CNT_W-1:0] vcount,
  output logic             hsync,
  output logic             vsync,
  output logic             hblnk,
  output logic             vblnk,
  output logic             frame_start,
  input  logic             upd_req,
  input  logic             upd_done,
  output logic             upd_gnt,
  output logic             upd_overrun
);

  // First line on which the update window is closed again.
  localparam logic [CNT_W-1:0] WIN_END = CNT_W'(V_TOTAL - GUARD_LINES);

  logic [CNT_W-1:0] vcount_nxt;
  logic             vblnk_nxt;
  logic             win_cur, win_nxt;
  upd_state_t       state_reg, state_next;
  logic             gnt_reg, gnt_next;
  logic             ovr_reg, ovr_next;

  vga_timing_gen #(
    .H_TOTAL      (H_TOTAL),
    .H_ACTIVE     (H_ACTIVE),
    .H_SYNC_BEGIN (H_SYNC_BEGIN),
    .H_SYNC_STOP  (H_SYNC_STOP),
    .V_TOTAL      (V_TOTAL),
    .V_ACTIVE     (V_ACTIVE),
    .V_SYNC_BEGIN (V_SYNC_BEGIN),
    .V_SYNC_STOP  (V_SYNC_STOP)
  ) u_timing (
    .clk         (clk),
    .rst         (rst),
    .hcount      (hcount),
    .vcount      (vcount),
    .hsync       (hsync),
    .vsync       (vsync),
    .hblnk       (hblnk),
    .vblnk       (vblnk),
    .frame_start (frame_start),
    .vcount_nxt  (vcount_nxt),
    .vblnk_nxt   (vblnk_nxt)
  );

  assign win_cur = vblnk && (vcount < WIN_END);
  assign win_nxt = vblnk_nxt && (vcount_nxt < WIN_END);

  // Arbiter next state: done wins over a simultaneous window close.
  // A request on the very last window cycle is not granted (win_nxt guard).
  always_comb begin
    state_next = state_reg;
    gnt_next   = 1'b0;
    ovr_next   = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (upd_req && win_cur && win_nxt) begin
          state_next = GRANTED;
          gnt_next   = 1'b1;
        end
      end
      GRANTED: begin
        if (upd_done) begin
          state_next = USED;
        end else if (!win_nxt) begin
          state_next = USED;
          ovr_next   = 1'b1;
        end else begin
          gnt_next = 1'b1;
        end
      end
      USED: begin
        if (frame_start) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Arbiter state and registered grant/overrun outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      gnt_reg   <= 1'b0;
      ovr_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      gnt_reg   <= gnt_next;
      ovr_reg   <= ovr_next;
    end
  end

  assign upd_gnt     = gnt_reg;
  assign upd_overrun = ovr_reg;

endmodule

// File: tb/tb_vga_frame_ctrl.sv
// Bench for vga_frame_ctrl: one full-size instance for line timing and two
// shrunken-timing instances (guard 1 and guard 4) for frame-level behaviour.
// A position-based model predicts every output every cycle.
module tb_vga_frame_ctrl;
  import vga_cfg_pkg::*;

  localparam int N = 3;
  // Shrunken timing: 40 clocks/line, 30 lines/frame.
  localparam int SH_T = 40, SH_A = 32, SH_SS = 34, SH_SE = 38;
  localparam int SV_T = 30, SV_A = 20, SV_SS = 22, SV_SE = 25;
  localparam int SF   = SH_T * SV_T;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic upd_req = 1'b0;
  logic upd_done = 1'b0;

  logic [10:0] hc [N];
  logic [10:0] vc [N];
  logic hs [N], vs [N], hb [N], vb [N], fs [N], gnt [N], ovr [N];

  always #5 clk = ~clk;

  vga_frame_ctrl #(.GUARD_LINES(1)) dut_full (
    .clk(clk), .rst(rst), .hcount(hc[0]), .vcount(vc[0]), .hsync(hs[0]), .vsync(vs[0]),
    .hblnk(hb[0]), .vblnk(vb[0]), .frame_start(fs[0]), .upd_req(upd_req),
    .upd_done(upd_done), .upd_gnt(gnt[0]), .upd_overrun(ovr[0]));

  vga_frame_ctrl #(.GUARD_LINES(1), .H_TOTAL(SH_T), .H_ACTIVE(SH_A), .H_SYNC_BEGIN(SH_SS),
    .H_SYNC_STOP(SH_SE), .V_TOTAL(SV_T), .V_ACTIVE(SV_A), .V_SYNC_BEGIN(SV_SS),
    .V_SYNC_STOP(SV_SE)) dut_g1 (
    .clk(clk), .rst(rst), .hcount(hc[1]), .vcount(vc[1]), .hsync(hs[1]), .vsync(vs[1]),
    .hblnk(hb[1]), .vblnk(vb[1]), .frame_start(fs[1]), .upd_req(upd_req),
    .upd_done(upd_done), .upd_gnt(gnt[1]), .upd_overrun(ovr[1]));

  vga_frame_ctrl #(.GUARD_LINES(4), .H_TOTAL(SH_T), .H_ACTIVE(SH_A), .H_SYNC_BEGIN(SH_SS),
    .H_SYNC_STOP(SH_SE), .V_TOTAL(SV_T), .V_ACTIVE(SV_A), .V_SYNC_BEGIN(SV_SS),
    .V_SYNC_STOP(SV_SE)) dut_g4 (
    .clk(clk), .rst(rst), .hcount(hc[2]), .vcount(vc[2]), .hsync(hs[2]), .vsync(vs[2]),
    .hblnk(hb[2]), .vblnk(vb[2]), .frame_start(fs[2]), .upd_req(upd_req),
    .upd_done(upd_done), .upd_gnt(gnt[2]), .upd_overrun(ovr[2]));

  int ht  [N] = '{H_TOTAL_TIME,  SH_T,  SH_T};
  int ha  [N] = '{H_ACTIVE_TIME, SH_A,  SH_A};
  int hss [N] = '{H_SYNC_START,  SH_SS, SH_SS};
  int hse [N] = '{H_SYNC_END,    SH_SE, SH_SE};
  int vt  [N] = '{V_TOTAL_TIME,  SV_T,  SV_T};
  int va  [N] = '{V_ACTIVE_TIME, SV_A,  SV_A};
  int vss [N] = '{V_SYNC_START,  SV_SS, SV_SS};
  int vse [N] = '{V_SYNC_END,    SV_SE, SV_SE};
  int gl  [N] = '{1, 1, 4};

  // Model state: position within the frame, "outputs held at zero" flag,
  // whether a grant is live, and whether this frame's grant is spent.
  int m_pos [N];
  bit m_zero [N];
  bit m_gnt [N], m_ovr [N], m_used [N];

  int checks = 0;
  int errors = 0;
  bit abort = 1'b0;

  // Observation counters for directed checks.
  int fs_cnt [N], vs_cnt [N], vb_cnt [N], hb_cnt [N], hs_cnt [N], ovr_cnt [N];
  int rise_v [N], rise_h [N], ovr_v [N], ovr_h [N];
  bit prev_gnt [N];

  function automatic bit in_win(int d, int p);
    int v;
    v = p / ht[d];
    return (v >= va[d]) && (v < vt[d] - gl[d]);
  endfunction

  function automatic logic [28:0] exp_vec(int d);
    int h, v;
    h = m_pos[d] % ht[d];
    v = m_pos[d] / ht[d];
    if (m_zero[d]) return '0;
    return {11'(h), 11'(v), (h >= hss[d]) && (h < hse[d]), (v >= vss[d]) && (v < vse[d]),
            h >= ha[d], v >= va[d], m_pos[d] == 0, m_gnt[d], m_ovr[d]};
  endfunction

  // Advance the model across one clock edge using the inputs present now.
  task automatic model_edge(int d);
    int nxt;
    bit fs_now;
    if (rst) begin
      m_pos[d] = 0; m_zero[d] = 1'b1;
      m_gnt[d] = 1'b0; m_ovr[d] = 1'b0; m_used[d] = 1'b0;
      return;
    end
    nxt    = (m_pos[d] + 1) % (ht[d] * vt[d]);
    fs_now = !m_zero[d] && (m_pos[d] == 0);
    m_ovr[d] = 1'b0;
    if (m_gnt[d]) begin
      if (upd_done) begin
        m_gnt[d] = 1'b0; m_used[d] = 1'b1;
      end else if (!in_win(d, nxt)) begin
        m_gnt[d] = 1'b0; m_used[d] = 1'b1; m_ovr[d] = 1'b1;
      end
    end else if (m_used[d]) begin
      if (fs_now) m_used[d] = 1'b0;
    end else if (!m_zero[d] && upd_req && in_win(d, m_pos[d]) && in_win(d, nxt)) begin
      m_gnt[d] = 1'b1;
    end
    m_pos[d]  = nxt;
    m_zero[d] = 1'b0;
  endtask

  task automatic chk(string tag, int observed, int expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // One clock: predict, clock, then compare every instance against the model.
  task automatic step();
    logic [28:0] obs;
    if (abort) return;
    for (int d = 0; d < N; d++) model_edge(d);
    @(posedge clk);
    #1;
    for (int d = 0; d < N; d++) begin
      obs = {hc[d], vc[d], hs[d], vs[d], hb[d], vb[d], fs[d], gnt[d], ovr[d]};
      checks++;
      assert (obs === exp_vec(d)) else begin
        errors++;
        $error("FAIL outputs dut=%0d pos=%0d observed=%h expected=%h", d, m_pos[d], obs, exp_vec(d));
      end
      if (fs[d]) fs_cnt[d]++;
      if (vs[d]) vs_cnt[d]++;
      if (vb[d]) vb_cnt[d]++;
      if (hb[d]) hb_cnt[d]++;
      if (hs[d]) hs_cnt[d]++;
      if (ovr[d]) begin ovr_cnt[d]++; ovr_v[d] = int'(vc[d]); ovr_h[d] = int'(hc[d]); end
      if (gnt[d] && !prev_gnt[d]) begin rise_v[d] = int'(vc[d]); rise_h[d] = int'(hc[d]); end
      prev_gnt[d] = gnt[d];
    end
    if (errors >= 40) abort = 1'b1;
  endtask

  task automatic clear_counts();
    for (int d = 0; d < N; d++) begin
      fs_cnt[d] = 0; vs_cnt[d] = 0; vb_cnt[d] = 0; hb_cnt[d] = 0; hs_cnt[d] = 0;
      ovr_cnt[d] = 0; rise_v[d] = -1; rise_h[d] = -1; ovr_v[d] = -1; ovr_h[d] = -1;
    end
  endtask

  // Step until the small-timing model shows (v,h); an expired budget is a failure.
  task automatic run_until(int v, int h, int budget);
    int n;
    n = 0;
    while (!(!m_zero[1] && m_pos[1] == v * SH_T + h)) begin
      if (n >= budget || abort) begin
        checks++; errors++;
        $error("FAIL run_until target=(%0d,%0d) reached=%0d budget=%0d", v, h, n, budget);
        return;
      end
      step();
      n++;
    end
  endtask

  initial begin
    for (int d = 0; d < N; d++) prev_gnt[d] = 1'b0;
    clear_counts();

    // Reset: everything zero, no frame strobe.
    rst = 1'b1;
    repeat (3) step();
    chk("reset_fs_count", fs_cnt[1], 0);
    chk("reset_hcount", int'(hc[0]), 0);

    // One full-size line: blanking/sync widths and the vcount step at the wrap.
    rst = 1'b0;
    clear_counts();
    step();
    chk("first_hcount", int'(hc[0]), 1);
    repeat (H_TOTAL_TIME - 1) step();
    chk("line_hblnk_cycles", hb_cnt[0], H_TOTAL_TIME - H_ACTIVE_TIME);
    chk("line_hsync_cycles", hs_cnt[0], H_SYNC_END - H_SYNC_START);
    chk("line_wrap_vcount", int'(vc[0]), 1);
    chk("line_wrap_hcount", int'(hc[0]), 0);
    repeat (2 * H_TOTAL_TIME) step();

    // Two small frames: one strobe per frame, vsync/vblnk line counts.
    run_until(0, 0, SF + 10);
    clear_counts();
    repeat (2 * SF) step();
    chk("frame_start_count", fs_cnt[1], 2);
    chk("vsync_cycles", vs_cnt[1], 2 * (SV_SE - SV_SS) * SH_T);
    chk("vblnk_cycles", vb_cnt[1], 2 * (SV_T - SV_A) * SH_T);

    // Early request waits for the window; done pulse ends the grant cleanly.
    run_until(5, 0, SF + 10);
    upd_req = 1'b1;
    clear_counts();
    run_until(22, 0, SF + 10);
    chk("grant_rise_line", rise_v[1], SV_A);
    chk("grant_rise_pixel", rise_h[1], 1);
    chk("grant_rise_line_g4", rise_v[2], SV_A);
    upd_done = 1'b1;
    step();
    upd_done = 1'b0;
    chk("gnt_after_done", int'(gnt[1]), 0);

    // Frame already used: held request gets nothing until the next frame.
    run_until(19, 0, SF + 10);
    chk("no_regrant_same_frame", int'(gnt[1]), 0);
    chk("no_overrun_after_done", ovr_cnt[1], 0);

    // Held request, no done: window close revokes with a one-cycle overrun.
    clear_counts();
    run_until(29, 5, SF + 10);
    chk("regrant_line", rise_v[1], SV_A);
    chk("overrun_line_g1", ovr_v[1], SV_T - 1);
    chk("overrun_pixel_g1", ovr_h[1], 0);
    chk("overrun_cycles_g1", ovr_cnt[1], 1);
    chk("overrun_line_g4", ovr_v[2], SV_T - 4);
    chk("overrun_pixel_g4", ovr_h[2], 0);
    chk("overrun_cycles_g4", ovr_cnt[2], 1);

    // Done arriving exactly as the window closes counts as done.
    clear_counts();
    run_until(28, SH_T - 1, SF + 10);
    upd_done = 1'b1;
    step();
    upd_done = 1'b0;
    chk("close_with_done_overrun", ovr_cnt[1], 0);
    chk("close_with_done_gnt", int'(gnt[1]), 0);

    // Reset mid-grant: everything drops, no overrun, regrant only next vblank.
    run_until(24, 10, SF + 10);
    chk("granted_before_reset", int'(gnt[1]), 1);
    clear_counts();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("reset_mid_grant_gnt", int'(gnt[1]), 0);
    chk("reset_mid_grant_vcount", int'(vc[1]), 0);
    chk("reset_mid_grant_ovr", ovr_cnt[1] + ovr_cnt[2], 0);
    run_until(SV_A, 3, SF + 10);
    chk("regrant_after_reset_line", rise_v[1], SV_A);
    chk("regrant_after_reset_pixel", rise_h[1], 1);

    // Randomized traffic on request/done across several frames.
    repeat (8 * SF) begin
      upd_req  = ($urandom_range(0, 3) != 0);
      upd_done = ($urandom_range(0, 59) == 0);
      step();
    end
    upd_req = 1'b0;
    upd_done = 1'b0;
    repeat (10) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
